mult_div_unit: RTL

//  Multi-cycle multiply/divide unit in the EX stage of the 5-stage MIPS pipeline; owns HI/LO.

---
 rtl/mdu_pkg.sv | 18 +
 rtl/md_latency_counter.sv | 26 ++
 rtl/mult_div_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/md_latency_counter.sv
// Countdown that times a multiply/divide in flight; done marks the final busy cycle.
module md_latency_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; result is computed at accept and
// published after a fixed latency, with md_stall holding fetch while a consumer waits.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        md_stall
);

  // Returns {hi, lo}; the divisor is forced to 1 on the special cases so the
  // raw divide never sees zero or the INT_MIN / -1 overflow.
  function automatic logic [63:0] div_result(input logic is_signed,
                                             input logic [31:0] n,
                                             input logic [31:0] d);
    logic               ovf;
    logic [31:0]        d_safe;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    logic [31:0]        uq;
    logic [31:0]        ur;
    ovf    = is_signed && (n == 32'h8000_0000) && (d == 32'hFFFF_FFFF);
    d_safe = ((d == 32'd0) || ovf) ? 32'd1 : d;
    sq     = $signed(n) / $signed(d_safe);
    sr     = $signed(n) % $signed(d_safe);
    uq     = n / d_safe;
    ur     = n % d_safe;
    if (d == 32'd0)      return {n, 32'hFFFF_FFFF};
    else if (ovf)        return {32'h0000_0000, 32'h8000_0000};
    else if (is_signed)  return {sr, sq};
    else                 return {ur, uq};
  endfunction

  mdu_state_e         state;
  logic [31:0]        shadow_hi;
  logic [31:0]        shadow_lo;
  logic signed [63:0] mul_s;
  logic [63:0]        mul_u;
  logic [63:0]        res;
  logic               load;
  logic               done;
  logic [CNT_W-1:0]   load_value;

  assign mul_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign mul_u = {32'h0, a} * {32'h0, b};

  always_comb begin
    res = 64'h0;
    case (op)
      MDU_MULT:  res = mul_s;
      MDU_MULTU: res = mul_u;
      MDU_DIV:   res = div_result(1'b1, a, b);
      MDU_DIVU:  res = div_result(1'b0, a, b);
      default:   res = 64'h0;
    endcase
  end

  assign load       = (state == ST_IDLE) && start && !op[2];
  assign load_value = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  md_latency_counter #(
    .CNT_W (CNT_W)
  ) u_latency (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .value (load_value),
    .done  (done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      hi        <= 32'h0;
      lo        <= 32'h0;
      shadow_hi <= 32'h0;
      shadow_lo <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            shadow_hi <= res[63:32];
            shadow_lo <= res[31:0];
            state     <= ST_RUN;
          end else if (start && (op == MDU_MTHI)) begin
            hi <= a;
          end else if (start && (op == MDU_MTLO)) begin
            lo <= a;
          end
        end
        ST_RUN: begin
          if (done) begin
            hi    <= shadow_hi;
            lo    <= shadow_lo;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state == ST_RUN);
  assign md_stall = md_use & (start | busy);

endmodule
